// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared FSM state encodings and default timing constants for
//               the intersection light controller and its request front end.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        COOLDOWN = 2'd2
    } ped_state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 8;
    localparam int DEF_COOLDOWN_CYCLES = 16;
    localparam int DEF_CNT_W           = 8;

endpackage
`default_nettype wire

// File: rtl/ped_request_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ped_request_ctrl_if
// Description : Button/handshake bundle between the pedestrian request block
//               (slave) and its environment / light controller (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface ped_request_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             btn_raw;
    logic             ack;
    logic             req;
    logic             btn_clean;
    logic             busy;
    logic [CNT_W-1:0] req_count;

    modport master (
        output btn_raw,
        output ack,
        input  req,
        input  btn_clean,
        input  busy,
        input  req_count
    );

    modport slave (
        input  btn_raw,
        input  ack,
        output req,
        output btn_clean,
        output busy,
        output req_count
    );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronizer chain followed by a stable-count debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic din,
    output logic      dout
);
    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
    logic                   clean_q, clean_d;
    logic                   sync_b;

    assign sync_b = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        dcnt_d  = dcnt_q;
        clean_d = clean_q;
        if (sync_b == clean_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
            // Input has differed for the full window: accept the new level.
            clean_d = ~clean_q;
            dcnt_d  = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            dcnt_q  <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            dcnt_q  <= dcnt_d;
            clean_q <= clean_d;
        end
    end

    assign dout = clean_q;

endmodule
`default_nettype wire

// File: rtl/ped_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ped_request_ctrl
// Description : Turns a debounced pedestrian press into a held request with
//               ack handshake, cooldown and saturating request counter.
//               Optional: PED_COOLDOWN_LATCH_EN remembers a cooldown press.
// Revision    : 1.0 - initial release
// ============================================================================
module ped_request_ctrl
    import traffic_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ped_request_ctrl_if.slave  pif
);
    localparam int CCNT_W = $clog2(COOLDOWN_CYCLES + 1);

    logic              btn_clean;
    logic              btn_clean_q;
    logic              press;
    ped_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CCNT_W-1:0] ccnt_q, ccnt_d;
`ifdef PED_COOLDOWN_LATCH_EN
    logic              latch_q, latch_d;
`endif

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (pif.btn_raw),
        .dout (btn_clean)
    );

    assign press = btn_clean & ~btn_clean_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        ccnt_d  = ccnt_q;
`ifdef PED_COOLDOWN_LATCH_EN
        latch_d = latch_q;
`endif
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (press) begin
                    state_d = PENDING;
                    req_d   = 1'b1;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            PENDING: begin
                // Presses here are merged into the outstanding request.
                req_d = 1'b1;
                if (pif.ack) begin
                    state_d = COOLDOWN;
                    req_d   = 1'b0;
                    ccnt_d  = CCNT_W'(COOLDOWN_CYCLES);
                end
            end
            COOLDOWN: begin
                req_d = 1'b0;
`ifdef PED_COOLDOWN_LATCH_EN
                if (press) latch_d = 1'b1;
`endif
                if (ccnt_q <= CCNT_W'(1)) begin
                    state_d = IDLE;
`ifdef PED_COOLDOWN_LATCH_EN
                    if (latch_q || press) begin
                        state_d = PENDING;
                        req_d   = 1'b1;
                        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    end
                    latch_d = 1'b0;
`endif
                end else begin
                    ccnt_d = ccnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            ccnt_q      <= '0;
            btn_clean_q <= 1'b0;
`ifdef PED_COOLDOWN_LATCH_EN
            latch_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            ccnt_q      <= ccnt_d;
            btn_clean_q <= btn_clean;
`ifdef PED_COOLDOWN_LATCH_EN
            latch_q     <= latch_d;
`endif
        end
    end

    assign pif.req       = req_q;
    assign pif.btn_clean = btn_clean;
    assign pif.busy      = busy_q;
    assign pif.req_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ped_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ped_request_ctrl
// Description : Directed self-checking bench for ped_request_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ped_request_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ped_request_ctrl_if #(.CNT_W(8)) pif ();
    ped_request_ctrl_if #(.CNT_W(2)) pif2 ();

    ped_request_ctrl #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .COOLDOWN_CYCLES(16), .CNT_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    ped_request_ctrl #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .COOLDOWN_CYCLES(16), .CNT_W(2)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .pif (pif2)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        pif.btn_raw = 1'b0; pif.ack = 1'b0;
        pif2.btn_raw = 1'b0; pif2.ack = 1'b0;
        rst = 1'b1;
        tick(3);
        n_vec++; if (pif.req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", pif.req); end
        n_vec++; if (pif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", pif.busy); end
        n_vec++; if (pif.btn_clean !== 1'b0) begin n_err++; $display("FAIL reset_btn_clean got %b want 0", pif.btn_clean); end
        n_vec++; if (pif.req_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", pif.req_count); end
        #2 rst = 1'b0;
        tick(2);
    endtask

    task automatic test_bounce;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                pif.btn_raw = (c < 5);
                tick(1);
                n_vec++;
                if (pif.btn_clean !== 1'b0) begin
                    n_err++; $display("FAIL bounce_clean r=%0d c=%0d got %b want 0", r, c, pif.btn_clean);
                end
            end
        end
        pif.btn_raw = 1'b0;
        tick(12);
        n_vec++; if (pif.req !== 1'b0) begin n_err++; $display("FAIL bounce_req got %b want 0", pif.req); end
        n_vec++; if (pif.req_count !== 8'd0) begin n_err++; $display("FAIL bounce_count got %0d want 0", pif.req_count); end
    endtask

    task automatic test_clean_press;
        pif.btn_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            n_vec++;
            if (pif.btn_clean !== (k >= 10)) begin
                n_err++; $display("FAIL press_clean edge=%0d got %b want %b", k, pif.btn_clean, (k >= 10));
            end
            n_vec++;
            if (pif.req !== (k >= 11)) begin
                n_err++; $display("FAIL press_req edge=%0d got %b want %b", k, pif.req, (k >= 11));
            end
        end
        n_vec++; if (pif.req_count !== 8'd1) begin n_err++; $display("FAIL press_count got %0d want 1", pif.req_count); end
        n_vec++; if (pif.busy !== 1'b1) begin n_err++; $display("FAIL press_busy got %b want 1", pif.busy); end
    endtask

    task automatic test_handshake;
        pif.ack = 1'b1;
        pif.btn_raw = 1'b0;
        n_vec++; if (pif.req !== 1'b1) begin n_err++; $display("FAIL hs_req_before got %b want 1", pif.req); end
        tick(1);
        pif.ack = 1'b0;
        n_vec++; if (pif.req !== 1'b0) begin n_err++; $display("FAIL hs_req_after got %b want 0", pif.req); end
        n_vec++; if (pif.busy !== 1'b1) begin n_err++; $display("FAIL hs_busy_first got %b want 1", pif.busy); end
        for (int k = 2; k <= 16; k++) begin
            tick(1);
            n_vec++;
            if (pif.busy !== 1'b1) begin n_err++; $display("FAIL hs_busy cyc=%0d got %b want 1", k, pif.busy); end
        end
        tick(1);
        n_vec++; if (pif.busy !== 1'b0) begin n_err++; $display("FAIL hs_busy_end got %b want 0", pif.busy); end
        n_vec++; if (pif.req_count !== 8'd1) begin n_err++; $display("FAIL hs_count got %0d want 1", pif.req_count); end
        tick(4);
    endtask

    task automatic test_cooldown_press;
        pif.btn_raw = 1'b1;
        tick(11);
        n_vec++; if (pif.req !== 1'b1) begin n_err++; $display("FAIL cd_setup_req got %b want 1", pif.req); end
        n_vec++; if (pif.req_count !== 8'd2) begin n_err++; $display("FAIL cd_setup_count got %0d want 2", pif.req_count); end
        pif.btn_raw = 1'b0;
        tick(12);
        pif.ack = 1'b1;                 // held for three cycles
        tick(3);
        pif.ack = 1'b0;
        n_vec++; if (pif.req !== 1'b0) begin n_err++; $display("FAIL cd_held_ack_req got %b want 0", pif.req); end
        pif.btn_raw = 1'b1;
        tick(13);
        n_vec++; if (pif.busy !== 1'b1) begin n_err++; $display("FAIL cd_busy_late got %b want 1", pif.busy); end
        pif.btn_raw = 1'b0;
        tick(1);
`ifdef PED_COOLDOWN_LATCH_EN
        n_vec++; if (pif.req !== 1'b1) begin n_err++; $display("FAIL cd_end_req got %b want 1", pif.req); end
        n_vec++; if (pif.req_count !== 8'd3) begin n_err++; $display("FAIL cd_end_count got %0d want 3", pif.req_count); end
`else
        n_vec++; if (pif.req !== 1'b0) begin n_err++; $display("FAIL cd_end_req got %b want 0", pif.req); end
        n_vec++; if (pif.busy !== 1'b0) begin n_err++; $display("FAIL cd_end_busy got %b want 0", pif.busy); end
        n_vec++; if (pif.req_count !== 8'd2) begin n_err++; $display("FAIL cd_end_count got %0d want 2", pif.req_count); end
`endif
        tick(12);
    endtask

    task automatic test_merge;
`ifndef PED_COOLDOWN_LATCH_EN
        pif.btn_raw = 1'b1;
        tick(12);
        pif.btn_raw = 1'b0;
        tick(12);
`endif
        n_vec++; if (pif.req_count !== 8'd3) begin n_err++; $display("FAIL merge_first_count got %0d want 3", pif.req_count); end
        pif.btn_raw = 1'b1;
        tick(12);
        pif.btn_raw = 1'b0;
        tick(12);
        n_vec++; if (pif.req !== 1'b1) begin n_err++; $display("FAIL merge_req got %b want 1", pif.req); end
        n_vec++; if (pif.req_count !== 8'd3) begin n_err++; $display("FAIL merge_count got %0d want 3", pif.req_count); end
    endtask

    task automatic test_async_reset;
        pif.btn_raw = 1'b1;
        tick(5);
        #3 rst = 1'b1;
        #1;
        n_vec++; if (pif.req !== 1'b0) begin n_err++; $display("FAIL arst_req got %b want 0", pif.req); end
        n_vec++; if (pif.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got %b want 0", pif.busy); end
        n_vec++; if (pif.btn_clean !== 1'b0) begin n_err++; $display("FAIL arst_clean got %b want 0", pif.btn_clean); end
        n_vec++; if (pif.req_count !== 8'd0) begin n_err++; $display("FAIL arst_count got %0d want 0", pif.req_count); end
        @(posedge clk);
        #4 rst = 1'b0;
        tick(10);
        n_vec++; if (pif.req !== 1'b0) begin n_err++; $display("FAIL arst_req_e10 got %b want 0", pif.req); end
        n_vec++; if (pif.btn_clean !== 1'b1) begin n_err++; $display("FAIL arst_clean_e10 got %b want 1", pif.btn_clean); end
        tick(1);
        n_vec++; if (pif.req !== 1'b1) begin n_err++; $display("FAIL arst_req_e11 got %b want 1", pif.req); end
        pif.btn_raw = 1'b0;
    endtask

    task automatic test_saturation;
        for (int i = 1; i <= 5; i++) begin
            pif2.btn_raw = 1'b1;
            tick(12);
            pif2.btn_raw = 1'b0;
            pif2.ack = 1'b1;
            tick(1);
            pif2.ack = 1'b0;
            tick(20);
            n_vec++;
            if (pif2.req_count !== ((i < 3) ? 2'(i) : 2'd3)) begin
                n_err++; $display("FAIL sat_count cycle=%0d got %0d want %0d", i, pif2.req_count, (i < 3) ? i : 3);
            end
        end
        n_vec++; if (pif2.busy !== 1'b0) begin n_err++; $display("FAIL sat_busy got %b want 0", pif2.busy); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_handshake();
        test_cooldown_press();
        test_merge();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
